// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the 65C02 memory-side bus bridge.
package cpu_bus_pkg;

  typedef logic [1:0] state_t;
  localparam state_t IDLE     = 2'd0;
  localparam state_t EXT_WAIT = 2'd1;
  localparam state_t EXT_DONE = 2'd2;

  typedef enum logic {
    SEL_FAST = 1'b0,
    SEL_EXT  = 1'b1
  } src_sel_e;

  localparam logic [7:0] DI_ERR = 8'hFF;

endpackage

// File: rtl/cpu_bus_bridge_if.sv
// CPU-side and external-side signals of the bus bridge; master is the bridge's view.
interface cpu_bus_bridge_if;
  logic [15:0] AB;
  logic        WE;
  logic [7:0]  DO;
  logic [7:0]  DI;
  logic        RDY;
  logic        ext_req;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic [7:0]  ext_rdata;
  logic        ext_ack;
  logic        bus_err;

  modport master (
    input  AB, WE, DO, ext_rdata, ext_ack,
    output DI, RDY, ext_req, ext_we, ext_addr, ext_wdata, bus_err
  );

  modport slave (
    output AB, WE, DO, ext_rdata, ext_ack,
    input  DI, RDY, ext_req, ext_we, ext_addr, ext_wdata, bus_err
  );
endinterface

// File: rtl/cpu_fast_ram.sv
// Single-port zero-page/stack RAM with registered read; read data holds when not enabled.
module cpu_fast_ram #(
  parameter int unsigned AW = 9
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_o       <= mem_q[addr_i];
    end
  end
endmodule

// File: rtl/cpu_bus_bridge.sv
// 65C02 memory stage: fast on-chip RAM plus a req/ack external port with timeout.
// Define CPU_BUS_POSTED_WRITE_EN for a one-entry posted write buffer on the external port.
module cpu_bus_bridge
  import cpu_bus_pkg::*;
#(
  parameter int unsigned FAST_AW = 9,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             RST,
  cpu_bus_bridge_if.master bus
);
  localparam int unsigned   CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  src_sel_e      sel_q, sel_d;
  logic          rdy_q, req_q, req_d, we_q, we_d, err_q, err_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d, rdata_q, rdata_d, ram_rdata;
  logic [CW-1:0] cnt_q, cnt_d;

  logic is_fast, slow_acc, ack_hit, tmo_hit;
  logic wb_busy, direct, post, to_pend, pend_fire;
  logic [15:0] pend_addr;
  logic        pend_we;
  logic [7:0]  pend_wdata;

  assign is_fast  = 32'(bus.AB) < (32'd1 << FAST_AW);
  assign slow_acc = rdy_q && !is_fast;
  assign ack_hit  = req_q && bus.ext_ack;
  // Ack has priority over a timeout landing in the same cycle.
  assign tmo_hit  = req_q && !bus.ext_ack && (cnt_q == CNT_LAST);

`ifdef CPU_BUS_POSTED_WRITE_EN
  logic        wb_busy_q, pend_q, pend_we_q;
  logic [15:0] pend_addr_q;
  logic [7:0]  pend_wdata_q;

  assign wb_busy    = wb_busy_q;
  assign to_pend    = slow_acc && wb_busy_q;
  assign post       = slow_acc && !wb_busy_q && bus.WE;
  assign direct     = slow_acc && !wb_busy_q && !bus.WE;
  assign pend_fire  = pend_q && !req_q && !wb_busy_q;
  assign pend_addr  = pend_addr_q;
  assign pend_we    = pend_we_q;
  assign pend_wdata = pend_wdata_q;

  always_ff @(posedge clk) begin
    if (!RST) begin
      wb_busy_q    <= 1'b0;
      pend_q       <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
    end else begin
      if (post)                               wb_busy_q <= 1'b1;
      else if (wb_busy_q && (ack_hit || tmo_hit)) wb_busy_q <= 1'b0;
      if (to_pend) begin
        pend_q       <= 1'b1;
        pend_we_q    <= bus.WE;
        pend_addr_q  <= bus.AB;
        pend_wdata_q <= bus.DO;
      end else if (pend_fire) begin
        pend_q <= 1'b0;
      end
    end
  end
`else
  assign wb_busy    = 1'b0;
  assign to_pend    = 1'b0;
  assign post       = 1'b0;
  assign direct     = slow_acc;
  assign pend_fire  = 1'b0;
  assign pend_addr  = '0;
  assign pend_we    = 1'b0;
  assign pend_wdata = '0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (req_q) cnt_d = cnt_q + CW'(1);
    if (ack_hit || tmo_hit) begin
      req_d = 1'b0;
      err_d = tmo_hit;
      if (!wb_busy) begin
        state_d = EXT_DONE;
        rdata_d = ack_hit ? bus.ext_rdata : DI_ERR;
      end
    end
    if (rdy_q) begin
      state_d = IDLE;
      sel_d   = is_fast ? SEL_FAST : SEL_EXT;
    end
    if (direct || to_pend) state_d = EXT_WAIT;
    if (direct || post) begin
      req_d   = 1'b1;
      we_d    = bus.WE;
      addr_d  = bus.AB;
      wdata_d = bus.DO;
      cnt_d   = '0;
    end else if (pend_fire) begin
      req_d   = 1'b1;
      we_d    = pend_we;
      addr_d  = pend_addr;
      wdata_d = pend_wdata;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q <= IDLE;
      rdy_q   <= 1'b1;
      sel_q   <= SEL_EXT;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != EXT_WAIT);
      sel_q   <= sel_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  cpu_fast_ram #(
    .AW(FAST_AW)
  ) u_fast_ram (
    .clk_i  (clk),
    .en_i   (RST && rdy_q && is_fast),
    .we_i   (bus.WE),
    .addr_i (bus.AB[FAST_AW-1:0]),
    .wdata_i(bus.DO),
    .rdata_o(ram_rdata)
  );

  assign bus.DI        = (sel_q == SEL_FAST) ? ram_rdata : rdata_q;
  assign bus.RDY       = rdy_q;
  assign bus.ext_req   = req_q;
  assign bus.ext_we    = we_q;
  assign bus.ext_addr  = addr_q;
  assign bus.ext_wdata = wdata_q;
  assign bus.bus_err   = err_q;
endmodule

// File: doc/cpu_bus_bridge.md
Name: cpu_bus_bridge

Overview:
- Memory-side stage directly downstream of the 65C02 core.
- Consumes the core's AB/WE/write data and returns read data plus RDY.
- Serves a single-cycle on-chip fast RAM (zero page + stack).
- Bridges every other address to an external req/ack port with wait-state insertion, a timeout, and an error pulse.

Parameters:
- FAST_AW, 9: fast RAM address width; fast region is 0x0000 .. 2^FAST_AW-1.
- TIMEOUT, 255: maximum cycles in EXT_WAIT before a forced termination (>=2).

Ports:
- clk  in  1  CPU clock
- RST  in  1  synchronous reset, active-low
- AB  in  16  CPU address bus
- WE  in  1  CPU write enable
- DO  in  8  CPU write data
- DI  out  8  read data to CPU data bus
- RDY  out  1  CPU ready; 0 = CPU holds AB/WE/DO
- ext_req  out  1  external request
- ext_we  out  1  external write
- ext_addr  out  16  external address
- ext_wdata  out  8  external write data
- ext_rdata  in  8  external read data
- ext_ack  in  1  external acknowledge, single-cycle
- bus_err  out  1  timeout pulse

Behaviour:
- Timing model: CPU presents AB/WE in cycle N. An access is accepted at the posedge ending N only if RDY=1. Read data is valid on DI throughout cycle N+1.
- Reset (RST=0 at posedge):
  - state=IDLE, RDY=1, ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0, DI=0, bus_err=0, timeout counter=0.
  - Fast RAM contents are untouched.
  - An access in flight is abandoned: req drops the next cycle, and a late ack is ignored.
- States: IDLE (RDY=1), EXT_WAIT (RDY=0), EXT_DONE (RDY=1). RDY is a registered decode of state.
- Fast region, accepted:
  - Write: RAM[AB] <= DO at the posedge ending N.
  - Read: DI in N+1 = RAM[AB]. No stall.
  - A fast access is legal in IDLE or EXT_DONE.
- Slow region, accepted:
  - At the posedge: ext_addr/ext_we/ext_wdata are latched, ext_req=1, state→EXT_WAIT, counter cleared.
  - In EXT_WAIT, AB is ignored. ext_req and its payload stay stable until ack.
- ack sampled in EXT_WAIT: ext_req=0, rdata latched, state→EXT_DONE. The minimum slow access is 1 stall cycle (ack in the first req cycle).
- Timeout: counter reaches TIMEOUT-1 without ack → ext_req=0, rdata=8'hFF, state→EXT_DONE, bus_err=1 for exactly the EXT_DONE cycle.
- EXT_DONE:
  - DI=rdata (don't-care for writes).
  - The AB presented in this cycle is a new access, decoded exactly as from IDLE. A slow access goes straight back to EXT_WAIT; otherwise the next state is IDLE.
- ack outside EXT_WAIT is ignored.
- ack and timeout in the same cycle: ack wins, no bus_err.
- DI source select is registered with each accepted access, so DI holds its value while RDY=0.
- Address 0xFFFF and region wrap need no special handling. The boundary is AB < 2^FAST_AW.

Optional Feature:
- Macro: CPU_BUS_POSTED_WRITE_EN.
- Enabled:
  - One-entry write buffer. A slow write accepted with the buffer empty does not stall: RDY stays 1, and the buffer drives ext_req from the next cycle.
  - Fast accesses proceed while the buffer drains.
  - A slow access accepted while the buffer is busy is latched into a pending slot. RDY=0 from the next cycle until the buffer drains and the pending access completes under normal EXT_WAIT/EXT_DONE rules.
  - A posted-write timeout pulses bus_err for one cycle and drops the data.
- Disabled: slow writes stall exactly like reads.

Decomposition:
- Package cpu_bus_pkg holds:
  - state enum (IDLE, EXT_WAIT, EXT_DONE)
  - DI_ERR = 8'hFF
  - source-select encoding (FAST, EXT)
- Sub-module cpu_fast_ram: synchronous single-port RAM of 2^FAST_AW x 8 with registered read and write enable.

Test Plan:
- Write 0x5A to 0x0012, then read 0x0012 → DI=0x5A the next cycle, RDY never low.
- Read 0x8000, ack after 3 cycles with 0xC3 → RDY low 3 cycles; ext_req high 3 cycles with ext_addr=0x8000; DI=0xC3 in the EXT_DONE cycle.
- Slow read, ack in the first req cycle, EXT_DONE AB=0x9000 → 1 stall; immediate second req for 0x9000 with no IDLE cycle between.
- Read 0xD000 with no ack → RDY low for TIMEOUT cycles; DI=0xFF; bus_err high for exactly 1 cycle; req low after.
- RST low during EXT_WAIT, then ack after reset → RDY=1, ext_req=0; ack ignored; no bus_err.
- With CPU_BUS_POSTED_WRITE_EN: slow write 0xA000←0x11, then fast read, then slow read 0xB000 → no stall for the first two; read stalls until the write ack plus its own ack.
